irs3_readout_ctrl: RTL
======================

// Module: irs3_readout_ctrl
// PURPOSE
//  Sequences readout of one IRS3 storage block on a DDA rev D. Drives the IRS3
//  read-address and digitised-sample select lines (RD_ADDR_RST, RD_ADDR_ADV,
//  DOE, SMPALL, SMP, CH) and latches DAT[11:0]. Streams CH x SMP samples to
//  the event builder over a valid/ready handshake. One instance per DDA.
// PARAMETERS
//  NCHAN         8   channels read per block (CH counts 0..NCHAN-1, NCHAN<=8)
//  NSAMP         64  samples per channel (SMP counts 0..NSAMP-1, NSAMP<=64)
//  SETTLE        3   cycles after CH/SMP change before DAT is latched (>=1)
//  ADDR_RST_LEN  2   cycles RD_ADDR_RST is held high (>=1)
// PORTS
//  clk_i            in   1   system clock; all logic on rising edge
//  rst_n_i          in   1   synchronous active-low reset
//  start_i          in   1   start readout; sampled only in IDLE
//  block_i          in   9   target block, captured when start accepted
//  rd_addr_rst_o    out  1   IRS3 RD_ADDR_RST
//  rd_addr_adv_o    out  1   IRS3 RD_ADDR_ADV
//  doe_o            out  1   IRS3 DOE (data output enable)
//  smpall_o         out  1   IRS3 SMPALL; held 0 (single-sample mode)
//  smp_o            out  6   IRS3 SMP select
//  ch_o             out  3   IRS3 CH select
//  dat_i            in   12  IRS3 DAT
//  sample_o         out  12  latched sample
//  sample_ch_o      out  3   channel of sample_o
//  sample_smp_o     out  6   sample index of sample_o
//  valid_o          out  1   sample_o/tags valid
//  ready_i          in   1   downstream accepts when valid_o & ready_i
//  busy_o           out  1   high in any state except IDLE
//  done_o           out  1   one-cycle pulse after last sample accepted
// BEHAVIOUR
//  Reset (rst_n_i=0 at edge): state IDLE; all outputs 0; counters 0. Applies
//   from any state, mid-readout included; partial block discarded, no done_o.
//  States: IDLE, ARST, ADV_HI, ADV_LO, SETTLE, OUT, DONE.
//  IDLE: start_i=1 -> capture block_i into blk_cnt, go ARST. start_i ignored
//   in all other states (no queuing).
//  ARST: rd_addr_rst_o=1 for exactly ADDR_RST_LEN cycles; then ADV_HI if
//   blk_cnt!=0 else SETTLE.
//  ADV_HI/ADV_LO: rd_addr_adv_o=1 one cycle, 0 one cycle; blk_cnt decrements
//   in ADV_LO; after ADV_LO with blk_cnt==1 go SETTLE. Block N costs 2N cycles.
//  SETTLE: doe_o=1 (held until DONE); ch_o/smp_o stable; wait SETTLE cycles,
//   then sample_o<=dat_i, tags<=ch_o/smp_o, valid_o<=1, go OUT.
//  OUT: valid_o, sample_o, tags held constant while ready_i=0. On valid_o &
//   ready_i: valid_o<=0; advance smp_o; at NSAMP-1 wrap smp_o to 0 and advance
//   ch_o; if ch_o==NCHAN-1 and smp_o==NSAMP-1 go DONE, else SETTLE.
//  Order: ch-major: (0,0),(0,1)..(0,NSAMP-1),(1,0)..(NCHAN-1,NSAMP-1).
//  DONE: done_o=1 one cycle; doe_o, smp_o, ch_o <= 0; next IDLE.
//  Max throughput 1 sample per SETTLE+1 cycles with ready_i held 1.
//  First valid_o: start accepted at edge k -> valid_o rises at edge
//   k+ADDR_RST_LEN+2*block+SETTLE+1 (no extra bubble).
//  block_i changes after acceptance have no effect. Total samples per start
//   exactly NCHAN*NSAMP; no duplicates, no drops under any ready_i pattern.
//  smpall_o is constant 0 in this revision; SMP/CH only change in OUT->SETTLE.
// TESTING
//  block_i=0, ready_i=1: RD_ADDR_RST high 2 cycles, zero ADV pulses, 512
//   samples ch-major, first valid 6 cycles after start edge, done_o once.
//  block_i=5: exactly 5 RD_ADDR_ADV pulses, each 1 high/1 low; first valid at
//   edge k+16; IRS3 model DAT matches block 5 contents.
//  Random ready_i (50%): sample_o/tags stable while stalled; scoreboard sees
//   512 unique (ch,smp) in order, no loss or repeat.
//  start_i held high across whole readout: exactly one readout; new readout
//   starts only if start_i still high in IDLE after done_o.
//  rst_n_i=0 for one cycle during ADV_HI and again during OUT: all outputs 0
//   next cycle, no done_o; subsequent start gives a clean full readout.
//  NCHAN=1, NSAMP=4, SETTLE=1: 4 samples (0,0)..(0,3) at 1 per 2 cycles.

Source files
------------

// File: rtl/irs3_readout_ctrl_if.sv
// Bundle of IRS3 read-control lines plus the sample stream towards the event builder.
// The master side is the readout controller; the slave side is the IRS3 and the downstream consumer.
interface irs3_readout_ctrl_if;
    logic        start_i;
    logic [8:0]  block_i;
    logic        rd_addr_rst_o;
    logic        rd_addr_adv_o;
    logic        doe_o;
    logic        smpall_o;
    logic [5:0]  smp_o;
    logic [2:0]  ch_o;
    logic [11:0] dat_i;
    logic [11:0] sample_o;
    logic [2:0]  sample_ch_o;
    logic [5:0]  sample_smp_o;
    logic        valid_o;
    logic        ready_i;
    logic        busy_o;
    logic        done_o;

    modport master (
        input  start_i, block_i, dat_i, ready_i,
        output rd_addr_rst_o, rd_addr_adv_o, doe_o, smpall_o, smp_o, ch_o,
               sample_o, sample_ch_o, sample_smp_o, valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, block_i, dat_i, ready_i,
        input  rd_addr_rst_o, rd_addr_adv_o, doe_o, smpall_o, smp_o, ch_o,
               sample_o, sample_ch_o, sample_smp_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/irs3_readout_ctrl.sv
// Reads one IRS3 storage block: resets the read address, advances it to the target block,
// then walks CH x SMP in ch-major order and streams each latched DAT word over valid/ready.
module irs3_readout_ctrl #(
    parameter int NCHAN        = 8,
    parameter int NSAMP        = 64,
    parameter int SETTLE       = 3,
    parameter int ADDR_RST_LEN = 2
) (
    input logic                 clk_i,
    input logic                 rst_n_i,
    irs3_readout_ctrl_if.master bus
);
    localparam int CNT_MAX = (SETTLE > ADDR_RST_LEN) ? SETTLE : ADDR_RST_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARST, S_ADV_HI, S_ADV_LO, S_SETTLE, S_OUT, S_DONE
    } state_t;

    state_t             state, state_next;
    logic [8:0]         blk_cnt, blk_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               take_sample;
    logic               handshake;
    logic               last;

    assign handshake    = (state == S_OUT) && bus.valid_o && bus.ready_i;
    assign last         = (bus.ch_o == 3'(NCHAN - 1)) && (bus.smp_o == 6'(NSAMP - 1));
    assign bus.smpall_o = 1'b0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        blk_next    = blk_cnt;
        cnt_next    = cnt;
        take_sample = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start_i) begin
                    state_next = S_ARST;
                    blk_next   = bus.block_i;
                    cnt_next   = CNT_W'(ADDR_RST_LEN - 1);
                end
            end
            S_ARST: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (blk_cnt != '0) begin
                    state_next = S_ADV_HI;
                end else begin
                    state_next = S_SETTLE;
                    cnt_next   = CNT_W'(SETTLE);
                end
            end
            S_ADV_HI: state_next = S_ADV_LO;
            S_ADV_LO: begin
                blk_next = blk_cnt - 9'd1;
                if (blk_cnt == 9'd1) begin
                    state_next = S_SETTLE;
                    cnt_next   = CNT_W'(SETTLE);
                end else begin
                    state_next = S_ADV_HI;
                end
            end
            // First entry waits one extra cycle for DOE to drive DAT; later entries only wait
            // SETTLE cycles after the CH/SMP change made on the handshake edge.
            S_SETTLE: begin
                if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else begin
                    take_sample = 1'b1;
                    state_next  = S_OUT;
                end
            end
            S_OUT: begin
                if (handshake) begin
                    state_next = last ? S_DONE : S_SETTLE;
                    cnt_next   = CNT_W'(SETTLE - 1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: IRS3 control lines are registered from state_next so they are glitch-free
    // and still line up exactly with the state they belong to.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state             <= S_IDLE;
            blk_cnt           <= '0;
            cnt               <= '0;
            bus.rd_addr_rst_o <= 1'b0;
            bus.rd_addr_adv_o <= 1'b0;
            bus.doe_o         <= 1'b0;
            bus.busy_o        <= 1'b0;
            bus.done_o        <= 1'b0;
            bus.smp_o         <= '0;
            bus.ch_o          <= '0;
            bus.sample_o      <= '0;
            bus.sample_ch_o   <= '0;
            bus.sample_smp_o  <= '0;
            bus.valid_o       <= 1'b0;
        end else begin
            state             <= state_next;
            blk_cnt           <= blk_next;
            cnt               <= cnt_next;
            bus.rd_addr_rst_o <= (state_next == S_ARST);
            bus.rd_addr_adv_o <= (state_next == S_ADV_HI);
            bus.doe_o         <= (state_next inside {S_SETTLE, S_OUT});
            bus.busy_o        <= (state_next != S_IDLE);
            bus.done_o        <= (state_next == S_DONE);

            if (take_sample) begin
                bus.sample_o     <= bus.dat_i;
                bus.sample_ch_o  <= bus.ch_o;
                bus.sample_smp_o <= bus.smp_o;
                bus.valid_o      <= 1'b1;
            end else if (handshake) begin
                bus.valid_o <= 1'b0;
            end

            // The last sample wraps both selects to zero, which leaves them cleared in DONE.
            if (handshake) begin
                if (bus.smp_o == 6'(NSAMP - 1)) begin
                    bus.smp_o <= '0;
                    bus.ch_o  <= last ? 3'd0 : bus.ch_o + 3'd1;
                end else begin
                    bus.smp_o <= bus.smp_o + 6'd1;
                end
            end
        end
    end
endmodule
